// File: rtl/therm_pkg.sv
// Shared helpers for thermometer-code decoding.
// Latency: n/a (package of pure functions and constants).
// Backpressure: n/a.
//
// Functions take the code zero-extended to MAX_W bits, so any DATA_WIDTH up
// to MAX_W can reuse them without per-width copies.
package therm_pkg;

  localparam int MAX_W = 64;

  // Width of a binary count able to hold 0..dw inclusive.
  function automatic int lvl_width(input int dw);
    return $clog2(dw + 1);
  endfunction

  // A thermometer code is 2^k - 1: adding one carries through every set bit
  // and lands on a single bit above them, so the AND is zero only when the
  // ones are contiguous from bit 0. Zero-extension keeps all-ones valid.
  function automatic logic is_therm(input logic [MAX_W-1:0] code);
    return (code & (code + MAX_W'(1))) == '0;
  endfunction

  // Population count; equals k for a well-formed code.
  function automatic logic [7:0] ones_count(input logic [MAX_W-1:0] code);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_W; i++) begin
      cnt = cnt + {7'd0, code[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/therm_classify.sv
// Combinational classifier: checks thermometer form and returns the level k.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake, evaluated every cycle.
//
// Ports: code (DATA_WIDTH raw code) -> is_valid (well-formed), k (ones count).
module therm_classify
  import therm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LVL_WIDTH  = lvl_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] code,
  output logic                  is_valid,
  output logic [LVL_WIDTH-1:0]  k
);

  logic [MAX_W-1:0] code_ext;

  assign code_ext = MAX_W'(code);
  assign is_valid = is_therm(code_ext);
  // Only meaningful when is_valid; the top ignores k for malformed codes.
  assign k        = LVL_WIDTH'(ones_count(code_ext));

endmodule

// File: rtl/therm_decode.sv
// Two-stage thermometer-to-binary decoder with bubble detection, last-good
// substitution and a saturating error counter.
// Latency: accept at edge N -> outValid after edge N+1; 1 beat/cycle.
// Backpressure: valid/ready; inReady = !s1Valid || s2Move, stalls when both
//               stages hold beats and outReady is low.
//
// Ports: clk, resetn (async active-low); codeIn/inValid/inReady upstream;
//        level/codeErr/outValid/outReady downstream; errCount/errClear.
module therm_decode
  import therm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LVL_WIDTH  = lvl_width(DATA_WIDTH),
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] codeIn,
  input  logic                  inValid,
  output logic                  inReady,
  output logic [LVL_WIDTH-1:0]  level,
  output logic                  codeErr,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [ERR_WIDTH-1:0]  errCount,
  input  logic                  errClear
);

  // S1: raw code register
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_code_q, s1_code_d;
  // S2: output register
  logic                  out_valid_q, out_valid_d;
  logic [LVL_WIDTH-1:0]  level_q, level_d;
  logic                  code_err_q, code_err_d;
  // Side state
  logic [LVL_WIDTH-1:0]  last_good_q, last_good_d;
  logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;

  logic                  s2_move;
  logic                  s1_to_s2;
  logic                  in_xfer;
  logic                  code_ok;
  logic [LVL_WIDTH-1:0]  code_k;

  therm_classify #(
    .DATA_WIDTH (DATA_WIDTH),
    .LVL_WIDTH  (LVL_WIDTH)
  ) u_classify (
    .code     (s1_code_q),
    .is_valid (code_ok),
    .k        (code_k)
  );

  // S2 can take a new beat when empty or when its beat leaves this edge.
  assign s2_move  = !out_valid_q || outReady;
  assign s1_to_s2 = s1_valid_q && s2_move;
  assign inReady  = !s1_valid_q || s2_move;
  assign in_xfer  = inValid && inReady;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_code_d   = s1_code_q;
    out_valid_d = out_valid_q;
    level_d     = level_q;
    code_err_d  = code_err_q;
    last_good_d = last_good_q;
    err_count_d = err_count_q;

    // S1 refills on the same edge it drains, so in_xfer wins.
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_code_d  = codeIn;
    end else if (s1_to_s2) begin
      s1_valid_d = 1'b0;
    end

    if (s1_to_s2) begin
      out_valid_d = 1'b1;
      if (code_ok) begin
        level_d     = code_k;
        code_err_d  = 1'b0;
        last_good_d = code_k;
      end else begin
        // Substitute the level held before this beat.
        level_d    = last_good_q;
        code_err_d = 1'b1;
      end
    end else if (outReady) begin
      out_valid_d = 1'b0;
    end

    // Clear beats a coincident increment; otherwise count up to all-ones.
    if (errClear) begin
      err_count_d = '0;
    end else if (s1_to_s2 && !code_ok && (err_count_q != {ERR_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + ERR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      out_valid_q <= 1'b0;
      level_q     <= '0;
      code_err_q  <= 1'b0;
      last_good_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
      code_err_q  <= code_err_d;
      last_good_q <= last_good_d;
      err_count_q <= err_count_d;
    end
  end

  assign outValid = out_valid_q;
  assign level    = level_q;
  assign codeErr  = code_err_q;
  assign errCount = err_count_q;

endmodule

// File: tb/tb_therm_decode.sv
// Bench for therm_decode: two instances share all stimulus, one with the
// default 8-bit error counter and one with a 2-bit counter for saturation.
// Expected beats are pushed on input acceptance and compared on output.
module tb_therm_decode;

  logic       clk;
  logic       resetn;
  logic [7:0] codeIn;
  logic       inValid;
  logic       outReady;
  logic       errClear;

  logic       inReady_a, outValid_a, codeErr_a;
  logic [3:0] level_a;
  logic [7:0] errCount_a;
  logic       inReady_b, outValid_b, codeErr_b;
  logic [3:0] level_b;
  logic [1:0] errCount_b;

  therm_decode #(.DATA_WIDTH(8), .ERR_WIDTH(8)) u_dut (
    .clk(clk), .resetn(resetn), .codeIn(codeIn), .inValid(inValid),
    .inReady(inReady_a), .level(level_a), .codeErr(codeErr_a),
    .outValid(outValid_a), .outReady(outReady), .errCount(errCount_a),
    .errClear(errClear)
  );

  therm_decode #(.DATA_WIDTH(8), .ERR_WIDTH(2)) u_dut_e2 (
    .clk(clk), .resetn(resetn), .codeIn(codeIn), .inValid(inValid),
    .inReady(inReady_b), .level(level_b), .codeErr(codeErr_b),
    .outValid(outValid_b), .outReady(outReady), .errCount(errCount_b),
    .errClear(errClear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lvl;
    logic       err;
    int         stamp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   chk_lat = 0;
  bit   acc = 0;
  int   m_last = 0;
  int   m_err8 = 0;
  int   m_err2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: search for k with code == 2^k - 1.
  task automatic model_push(input logic [7:0] code);
    exp_t e;
    int   k;
    k = -1;
    for (int i = 0; i <= 8; i++) begin
      if (int'(code) == ((1 << i) - 1)) k = i;
    end
    e.stamp = cyc;
    if (k >= 0) begin
      e.lvl  = 4'(k);
      e.err  = 1'b0;
      m_last = k;
    end else begin
      e.lvl = 4'(m_last);
      e.err = 1'b1;
      if (m_err8 < 255) m_err8++;
      if (m_err2 < 3) m_err2++;
    end
    q.push_back(e);
  endtask

  // One clock: sample handshakes at negedge, then return 1ns after posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc = inValid && inReady_a;
    if (acc) model_push(codeIn);
    if (outValid_a && outReady) begin
      if (q.size() == 0) begin
        chk("spurious_beat", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("level", 32'(level_a), 32'(e.lvl));
        chk("code_err", 32'(codeErr_a), 32'(e.err));
        chk("level_e2", 32'(level_b), 32'(e.lvl));
        chk("code_err_e2", 32'(codeErr_b), 32'(e.err));
        if (chk_lat) chk("latency", 32'(cyc - e.stamp), 32'd2);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Leaves inValid high so consecutive sends stream back to back.
  task automatic send(input logic [7:0] code);
    codeIn  = code;
    inValid = 1'b1;
    acc     = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step();
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || outValid_a); i++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_out_valid", 32'(outValid_a), 32'd0);
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_err8"}, 32'(errCount_a), 32'(m_err8));
    chk({tag, "_err2"}, 32'(errCount_b), 32'(m_err2));
  endtask

  initial begin
    logic [7:0] p3_codes [3];
    logic [1:0] sat_tbl [5];
    int         idx;
    p3_codes = '{8'h03, 8'h7F, 8'h1F};
    sat_tbl  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    resetn = 1'b0; codeIn = '0; inValid = 1'b0; outReady = 1'b0; errClear = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(outValid_a), 32'd0);
    chk("rst_level", 32'(level_a), 32'd0);
    chk("rst_code_err", 32'(codeErr_a), 32'd0);
    chk_err("rst");
    #5 resetn = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(inReady_a), 32'd1);

    // Valid stream at full rate, latency 2
    outReady = 1'b1;
    chk_lat  = 1'b1;
    send(8'h00); send(8'h01); send(8'h0F); send(8'hFF);
    drain();
    chk_err("valid_stream");

    // Bubble replaced by last good level
    send(8'h07); send(8'h05); send(8'h3F);
    drain();
    chk_err("bubble");
    chk_lat = 1'b0;

    // Backpressure: outReady low for 4 cycles with inValid high
    outReady = 1'b0;
    inValid  = 1'b1;
    idx      = 0;
    for (int i = 0; i < 4; i++) begin
      codeIn = p3_codes[idx];
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready", 32'(inReady_a), 32'd0);
    chk("bp_out_valid", 32'(outValid_a), 32'd1);
    chk("bp_level", 32'(level_a), 32'd2);
    step();
    chk("bp_level_stable", 32'(level_a), 32'd2);
    chk("bp_err_stable", 32'(codeErr_a), 32'd0);
    chk("bp_no_accept", 32'(acc), 32'd0);
    outReady = 1'b1;
    send(p3_codes[2]);
    drain();

    // Saturation with the 2-bit counter
    errClear = 1'b1;
    step();
    errClear = 1'b0;
    m_err8 = 0; m_err2 = 0;
    chk_err("clear");
    for (int i = 0; i < 5; i++) begin
      send(8'h05);
      drain();
      chk("sat_table", 32'(errCount_b), 32'(sat_tbl[i]));
      chk_err("sat");
    end
    // Sixth bad beat moves S1->S2 on the same edge as errClear
    send(8'h05);
    inValid  = 1'b0;
    errClear = 1'b1;
    step();
    errClear = 1'b0;
    m_err8 = 0; m_err2 = 0;
    chk_err("clear_prio");
    drain();
    chk_err("clear_prio_drained");

    // Reset with both stages full and lastGood nonzero
    outReady = 1'b0;
    send(8'h05);
    send(8'h0F);
    inValid = 1'b0;
    step();
    chk("pre_rst_in_ready", 32'(inReady_a), 32'd0);
    chk("pre_rst_err8", 32'(errCount_a), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(outValid_a), 32'd0);
    chk("mid_rst_err8", 32'(errCount_a), 32'd0);
    chk("mid_rst_err2", 32'(errCount_b), 32'd0);
    q.delete();
    m_last = 0; m_err8 = 0; m_err2 = 0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b1;
    send(8'h05);
    drain();
    chk_err("post_rst");

    // Random handshakes with mixed codes
    for (int i = 0; i < 400; i++) begin
      inValid  = 1'($urandom_range(0, 1));
      outReady = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) codeIn = 8'hFF >> $urandom_range(0, 8);
      else codeIn = 8'($urandom);
      step();
    end
    drain();
    chk_err("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/therm_decode.md
# therm_decode

Pipelined downstream consumer of thermometer codes: accepts a DATA_WIDTH-bit code per valid/ready beat, checks it for thermometer form, and emits its binary level (count of ones). Malformed codes (bubbles, gaps) are flagged per beat, counted in a saturating error counter, and replaced on the output by the last good level. Sits between the thermometer checker/flash-quantiser front end and the binary datapath.

## Interface
- DATA_WIDTH, 8: width of the thermometer code; must be ≥2.
- LVL_WIDTH, $clog2(DATA_WIDTH+1): width of the binary level.
- ERR_WIDTH, 8: width of the saturating error counter.
- clk  input  1  sole clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- codeIn  input  DATA_WIDTH  thermometer code from upstream.
- inValid  input  1  codeIn holds a beat.
- inReady  output  1  block accepts the beat this cycle.
- level  output  LVL_WIDTH  decoded level (or held last-good level).
- codeErr  output  1  this output beat came from a malformed code.
- outValid  output  1  level/codeErr hold a beat.
- outReady  input  1  downstream accepts the beat.
- errCount  output  ERR_WIDTH  number of malformed beats since reset/clear, saturating.
- errClear  input  1  synchronous clear of errCount.

## Operation
- Valid code: ones contiguous from bit 0, i.e. codeIn == 2^k − 1 for k in 0..DATA_WIDTH. All-zeros (k=0) and all-ones (k=DATA_WIDTH) are valid. Anything else is malformed.
- Level of a valid code = k, zero-extended to LVL_WIDTH.
- Two register stages, S1 and S2 (output). Handshake transfer = valid && ready on the same edge.
- S1 captures codeIn on an input transfer; holds raw code plus s1Valid.
- S1 → S2 move: classifies S1 code. Valid: S2.level = k, codeErr = 0, lastGood ← k. Malformed: S2.level = lastGood (value before this beat), codeErr = 1, errCount increments.
- errCount saturates at 2^ERR_WIDTH − 1; further errors leave it unchanged.
- errClear: errCount ← 0 next edge. errClear has priority over a same-cycle increment (result 0).
- Beats are never dropped, duplicated or reordered.

## Timing
- Reset (async assert, effective immediately): outValid=0, level=0, codeErr=0, errCount=0, lastGood=0, S1 empty. inReady=1 once resetn is high.
- S2 advance: s2Move = !outValid || outReady. S1 → S2 when s1Valid && s2Move.
- inReady = !s1Valid || s2Move (combinational, no dependency on inValid).
- Latency: input transfer at edge N → outValid high after edge N+1 when outReady held high; throughput 1 beat/cycle under continuous outReady.
- outValid=1 with outReady=0: level, codeErr stable until transfer.
- Full (S1 and S2 occupied, outReady=0): inReady=0; codeIn ignored.
- Simultaneous output transfer and S1 move: S2 reloads on same edge, outValid stays 1.
- Reset mid-stream: in-flight beats discarded, lastGood returns to 0.
- errCount updates on the same edge the malformed beat enters S2.

## Structure
- Shared package therm_pkg: function for valid-code check and ones-count, LVL_WIDTH derivation helper; reused by the checker stage.
- Sub-module therm_classify (combinational): code in → isValid, k out. Instantiated once between S1 and S2.
- Top therm_decode holds S1/S2 registers, handshake, lastGood, errCount.

## Test plan
- DATA_WIDTH=8, outReady=1, stream 0x00,0x01,0x0F,0xFF → levels 0,1,4,8, codeErr=0, each 2 edges after accept, one per cycle.
- Stream 0x07, 0x05, 0x3F → levels 3, 3 (codeErr=1), 6; errCount=1.
- outReady=0 for 4 cycles with inValid=1 → two beats accepted, inReady=0 after, output stable; release → beats delivered in order, none lost.
- ERR_WIDTH=2, 5 malformed beats → errCount 1,2,3,3,3; errClear coincident with 6th malformed beat → errCount 0.
- Assert resetn=0 while S1/S2 full → outValid=0, errCount=0 immediately; first post-reset malformed beat outputs level 0, codeErr=1.
- Random valid/ready toggling with mixed codes vs. reference model → exact level/codeErr sequence and errCount match.
